// File: rtl/hps_point_dispatcher_pkg.sv
// Shared types, mailbox layout and status-word helpers for the HPS point dispatcher.
package hps_point_dispatcher_pkg;

  typedef enum logic [3:0] {
    StIdleRd, StIdleWait, StIdleLatch,
    StHdrRd, StHdrWait, StHdrLatch,
    StPtRd, StPtWait, StPtLatch,
    StDispatch, StAckWait, StNext,
    StWbStatus, StWbClear
  } state_e;

  // Mailbox word addresses
  localparam int unsigned ADDR_READY = 0;
  localparam int unsigned ADDR_HDR   = 1;
  localparam int unsigned ADDR_PTS   = 2;

  // Point word fields
  localparam int unsigned PT_X_MSB   = 29;
  localparam int unsigned PT_X_LSB   = 20;
  localparam int unsigned PT_Y_MSB   = 17;
  localparam int unsigned PT_Y_LSB   = 8;
  localparam int unsigned PT_VAL_MSB = 7;
  localparam int unsigned PT_VAL_LSB = 0;

  // Header word fields
  localparam int unsigned HDR_MODE_BIT = 31;
  localparam int unsigned HDR_CNT_MSB  = 15;

  // Status word fields
  localparam int unsigned ST_VALID_BIT = 31;
  localparam int unsigned ST_OVF_BIT   = 30;
  localparam int unsigned ST_RNG_BIT   = 29;
  localparam int unsigned ST_TMO_BIT   = 28;

  function automatic logic [31:0] pack_status(input logic ovf, input logic rng,
                                              input logic tmo, input logic [15:0] done);
    logic [31:0] w;
    w               = '0;
    w[ST_VALID_BIT] = 1'b1;
    w[ST_OVF_BIT]   = ovf;
    w[ST_RNG_BIT]   = rng;
    w[ST_TMO_BIT]   = tmo;
    w[15:0]         = done;
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hps_point_dispatcher_if.sv
// Mailbox SRAM port plus the one-hot column request/acknowledge bundle.
interface hps_point_dispatcher_if #(
  parameter int unsigned AW     = 8,
  parameter int unsigned N_COLS = 64
) ();
  logic [AW-1:0]     sram_address;
  logic              sram_write;
  logic [31:0]       sram_writedata;
  logic [31:0]       sram_readdata;
  logic [N_COLS-1:0] col_select;
  logic [9:0]        row_select;
  logic [7:0]        pixel_color;
  logic [N_COLS-1:0] return_sig;

  modport master (
    output sram_address, sram_write, sram_writedata, col_select, row_select, pixel_color,
    input  sram_readdata, return_sig
  );

  modport slave (
    input  sram_address, sram_write, sram_writedata, col_select, row_select, pixel_color,
    output sram_readdata, return_sig
  );
endinterface

// File: rtl/hps_point_dispatcher_col_handshake.sv
// One-hot column request with acknowledge/timeout arbitration. Acknowledge beats timeout.
module hps_point_dispatcher_col_handshake #(
  parameter int unsigned N_COLS  = 64,
  parameter int unsigned TIMEOUT = 1023,
  localparam int unsigned CW     = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CW-1:0]     col,
  input  logic              active,
  input  logic [N_COLS-1:0] return_sig,
  output logic [N_COLS-1:0] col_select,
  output logic              ack,
  output logic              timeout
);
  // Timeout fires on the cycle the counter would reach TIMEOUT
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  logic [CW-1:0]     col_q;
  logic [9:0]        cnt_q;
  logic [N_COLS-1:0] sel_q;

  assign ack        = active && return_sig[col_q];
  assign timeout    = active && !ack && (cnt_q == TMO_LAST);
  assign col_select = sel_q;

  // Request register, latched column and wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= '0;
      cnt_q <= '0;
      sel_q <= '0;
    end else if (start) begin
      col_q <= col;
      cnt_q <= '0;
      sel_q <= N_COLS'(1) << col;
    end else if (active) begin
      if (ack || timeout) sel_q <= '0;
      else                cnt_q <= cnt_q + 10'd1;
    end
  end

endmodule

// File: rtl/hps_point_dispatcher.sv
// Polls the HPS mailbox, dispatches each point to a column writer, writes status back.
module hps_point_dispatcher
  import hps_point_dispatcher_pkg::*;
#(
  parameter int unsigned N_COLS      = 64,
  parameter int unsigned N_ROWS      = 480,
  parameter int unsigned AW          = 8,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned TIMEOUT     = 1023,
  parameter logic [7:0]  CONST_COLOR = 8'hFF
) (
  input  logic                  clock,
  input  logic                  reset,
  hps_point_dispatcher_if.master bus,
  output logic                  busy,
  output logic                  batch_done,
  output logic [15:0]           err_count
);
  localparam int unsigned CW       = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int unsigned MAX_PTS  = (1 << AW) - 2;
  localparam int unsigned LAT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  state_e        state_q, state_d;
  logic [7:0]    lat_q;
  logic [AW-1:0] count_q, idx_q;
  logic          mode_q, ovf_q, rng_q, tmo_q;
  logic [15:0]   done_q, err_q;
  logic [CW-1:0] x_q;
  logic [9:0]    y_q, row_q;
  logic [7:0]    val_q, pix_q;

  logic          ack, timeout, lat_done, pt_bad;
  logic [9:0]    rd_x, rd_y;
  logic [7:0]    rd_val;
  logic [15:0]   hdr_cnt;
  logic [AW-1:0] address;
  logic          write;
  logic [31:0]   writedata;

  assign rd_x     = bus.sram_readdata[PT_X_MSB:PT_X_LSB];
  assign rd_y     = bus.sram_readdata[PT_Y_MSB:PT_Y_LSB];
  assign rd_val   = bus.sram_readdata[PT_VAL_MSB:PT_VAL_LSB];
  assign hdr_cnt  = bus.sram_readdata[HDR_CNT_MSB:0];
  assign pt_bad   = (32'(rd_x) >= N_COLS) || (32'(rd_y) >= N_ROWS);
  assign lat_done = (lat_q == LAT_LAST[7:0]);

  hps_point_dispatcher_col_handshake #(
    .N_COLS (N_COLS),
    .TIMEOUT(TIMEOUT)
  ) u_col_handshake (
    .clock     (clock),
    .reset     (reset),
    .start     (state_q == StDispatch),
    .col       (x_q),
    .active    (state_q == StAckWait),
    .return_sig(bus.return_sig),
    .col_select(bus.col_select),
    .ack       (ack),
    .timeout   (timeout)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdleRd;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdleRd:    state_d = (RD_LAT > 1) ? StIdleWait : StIdleLatch;
      StIdleWait:  if (lat_done) state_d = StIdleLatch;
      StIdleLatch: state_d = (bus.sram_readdata != '0) ? StHdrRd : StIdleRd;
      StHdrRd:     state_d = (RD_LAT > 1) ? StHdrWait : StHdrLatch;
      StHdrWait:   if (lat_done) state_d = StHdrLatch;
      StHdrLatch:  state_d = (hdr_cnt == '0) ? StWbStatus : StPtRd;
      StPtRd:      state_d = (RD_LAT > 1) ? StPtWait : StPtLatch;
      StPtWait:    if (lat_done) state_d = StPtLatch;
      StPtLatch:   state_d = pt_bad ? StNext : StDispatch;
      StDispatch:  state_d = StAckWait;
      StAckWait:   if (ack || timeout) state_d = StNext;
      StNext:      state_d = (idx_q + AW'(1) == count_q) ? StWbStatus : StPtRd;
      StWbStatus:  state_d = StWbClear;
      StWbClear:   state_d = StIdleRd;
      default:     state_d = StIdleRd;
    endcase
  end

  // Batch bookkeeping, read-latency counter and per-point datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      lat_q   <= '0;
      count_q <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rng_q   <= 1'b0;
      tmo_q   <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      val_q   <= '0;
      row_q   <= '0;
      pix_q   <= '0;
    end else begin
      unique case (state_q)
        StIdleRd, StHdrRd, StPtRd: lat_q <= '0;
        StIdleWait, StHdrWait, StPtWait: lat_q <= lat_q + 8'd1;
        StIdleLatch: begin
          // Per-batch state clears as the header read begins
          if (bus.sram_readdata != '0) begin
            ovf_q  <= 1'b0;
            rng_q  <= 1'b0;
            tmo_q  <= 1'b0;
            done_q <= '0;
          end
        end
        StHdrLatch: begin
          mode_q <= bus.sram_readdata[HDR_MODE_BIT];
          idx_q  <= '0;
          // Clamp keeps point addresses inside the mailbox
          if (32'(hdr_cnt) > MAX_PTS) begin
            count_q <= AW'(MAX_PTS);
            ovf_q   <= 1'b1;
          end else begin
            count_q <= hdr_cnt[AW-1:0];
          end
        end
        StPtLatch: begin
          x_q   <= rd_x[CW-1:0];
          y_q   <= rd_y;
          val_q <= rd_val;
          if (pt_bad) begin
            rng_q <= 1'b1;
            err_q <= sat_inc16(err_q);
          end
        end
        StDispatch: begin
          row_q <= y_q;
          pix_q <= mode_q ? val_q : CONST_COLOR;
        end
        StAckWait: begin
          if (ack) begin
            done_q <= done_q + 16'd1;
          end else if (timeout) begin
            tmo_q <= 1'b1;
            err_q <= sat_inc16(err_q);
          end
        end
        StNext:  idx_q <= idx_q + AW'(1);
        default: ;
      endcase
    end
  end

  // SRAM address/write decode from the current state
  always_comb begin
    address   = AW'(ADDR_READY);
    write     = 1'b0;
    writedata = '0;
    unique case (state_q)
      StHdrRd, StHdrWait, StHdrLatch: address = AW'(ADDR_HDR);
      StPtRd, StPtWait, StPtLatch:    address = AW'(ADDR_PTS) + idx_q;
      StWbStatus: begin
        address   = AW'(ADDR_HDR);
        write     = 1'b1;
        writedata = pack_status(ovf_q, rng_q, tmo_q, done_q);
      end
      StWbClear: begin
        address = AW'(ADDR_READY);
        write   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.sram_address   = address;
  assign bus.sram_write     = write;
  assign bus.sram_writedata = writedata;
  assign bus.row_select     = row_q;
  assign bus.pixel_color    = pix_q;
  assign busy               = !(state_q inside {StIdleRd, StIdleWait, StIdleLatch});
  assign batch_done         = (state_q == StWbClear);
  assign err_count          = err_q;

endmodule

// File: tb/tb_hps_point_dispatcher.sv
// Bench for hps_point_dispatcher: mailbox SRAM model, column responder, batch-level model.
module tb_hps_point_dispatcher;
  localparam int unsigned NC  = 64;
  localparam int unsigned NR  = 480;
  localparam int unsigned AWT = 8;
  localparam int unsigned RDL = 2;
  localparam int unsigned TMO = 1023;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        busy, batch_done;
  logic [15:0] err_count;

  hps_point_dispatcher_if #(.AW(AWT), .N_COLS(NC)) bus ();

  hps_point_dispatcher #(
    .N_COLS     (NC),
    .N_ROWS     (NR),
    .AW         (AWT),
    .RD_LAT     (RDL),
    .TIMEOUT    (TMO),
    .CONST_COLOR(8'hFF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .batch_done(batch_done),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  // Mailbox SRAM: whole-image loads from the bench, writes from the DUT, RDL-cycle read pipe
  logic [31:0] mem   [256];
  logic [31:0] stage [256];
  logic        load_req = 1'b0;
  logic [7:0]  rd_p0, rd_p1;

  always @(posedge clock) begin
    rd_p0 <= bus.sram_address;
    rd_p1 <= rd_p0;
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= stage[i];
    end else if (bus.sram_write) begin
      mem[bus.sram_address] <= bus.sram_writedata;
    end
  end
  assign bus.sram_readdata = mem[rd_p1];

  // Column responder: acks after ack_delay cycles, optional noise on the other columns
  int unsigned ack_delay = 2;
  bit          ack_en    = 1'b1;
  bit          noise_en  = 1'b0;

  initial begin
    int held;
    logic [NC-1:0] noise;
    held = 0;
    bus.return_sig = '0;
    forever begin
      @(negedge clock);
      noise = noise_en ? {$urandom, $urandom} : '0;
      if (bus.col_select != '0) begin
        held++;
        noise = noise & ~bus.col_select;
        bus.return_sig = (ack_en && held > int'(ack_delay)) ? (noise | bus.col_select) : noise;
      end else begin
        held = 0;
        bus.return_sig = noise;
      end
    end
  end

  // Monitor: append-only logs of requests and writes, plus protocol counters
  logic [NC+17:0] disp_q [$];
  logic [39:0]    wr_q   [$];
  int done_pulses = 0, busy_cycles = 0, rd_nonzero = 0;
  int bad_onehot = 0, unstable = 0, run_len = 0, last_run = 0;
  logic [NC-1:0] prev_sel = '0;
  logic [9:0]    prev_row = '0;
  logic [7:0]    prev_pix = '0;

  always @(negedge clock) begin
    if (bus.sram_write) wr_q.push_back({bus.sram_address, bus.sram_writedata});
    if (batch_done) done_pulses++;
    if (busy) busy_cycles++;
    if (!bus.sram_write && bus.sram_address != '0) rd_nonzero++;
    if (bus.col_select != '0) begin
      if ($countones(bus.col_select) != 1) bad_onehot++;
      if (prev_sel == '0) begin
        disp_q.push_back({bus.col_select, bus.row_select, bus.pixel_color});
        run_len = 0;
      end else if (bus.col_select != prev_sel || bus.row_select != prev_row ||
                   bus.pixel_color != prev_pix) begin
        unstable++;
      end
      run_len++;
    end else if (prev_sel != '0) begin
      last_run = run_len;
    end
    prev_sel = bus.col_select;
    prev_row = bus.row_select;
    prev_pix = bus.pixel_color;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;
  logic [31:0] pts_q [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pt(input int x, input int y, input int v);
    logic [31:0] w;
    w        = '0;
    w[29:20] = 10'(x);
    w[17:8]  = 10'(y);
    w[7:0]   = 8'(v);
    return w;
  endfunction

  task automatic load_batch(input int cnt, input bit mode);
    int eff;
    eff = (cnt > 254) ? 254 : cnt;
    for (int i = 0; i < 256; i++) stage[i] = '0;
    stage[1] = {mode, 15'd0, 16'(cnt)};
    for (int i = 0; i < eff; i++) stage[2+i] = pts_q[i];
    stage[0] = 32'($urandom_range(1, 255));
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
  endtask

  // Model the whole batch from the mailbox rules, run it, compare the observed effects
  task automatic run_batch(input string tag, input int cnt, input bit mode, input int budget);
    int eff, done, d0, w0, p0, x, y, v;
    bit ovf, rng, tmo;
    logic [NC-1:0]  oh;
    logic [NC+17:0] exp_disp [$];
    logic [31:0]    status;
    eff  = (cnt > 254) ? 254 : cnt;
    ovf  = (cnt > 254);
    rng  = 1'b0;
    tmo  = 1'b0;
    done = 0;
    for (int i = 0; i < eff; i++) begin
      x = int'(pts_q[i][29:20]);
      y = int'(pts_q[i][17:8]);
      v = int'(pts_q[i][7:0]);
      if (x >= int'(NC) || y >= int'(NR)) begin
        rng = 1'b1;
        exp_err++;
      end else begin
        oh    = '0;
        oh[x] = 1'b1;
        exp_disp.push_back({oh, 10'(y), mode ? 8'(v) : 8'hFF});
        if (ack_en) done++;
        else begin
          tmo = 1'b1;
          exp_err++;
        end
      end
    end
    status = 32'h8000_0000 | (ovf ? 32'h4000_0000 : 32'h0) | (rng ? 32'h2000_0000 : 32'h0) |
             (tmo ? 32'h1000_0000 : 32'h0) | 32'(done);
    d0 = disp_q.size();
    w0 = wr_q.size();
    p0 = done_pulses;
    load_batch(cnt, mode);
    for (int c = 0; c < budget && done_pulses == p0; c++) @(negedge clock);
    repeat (6) @(negedge clock);
    check({tag, " batch_done pulses"}, 128'(done_pulses - p0), 128'(1));
    check({tag, " request count"}, 128'(disp_q.size() - d0), 128'(exp_disp.size()));
    for (int i = 0; i < exp_disp.size() && d0 + i < disp_q.size(); i++)
      check($sformatf("%s request %0d", tag, i), 128'(disp_q[d0+i]), 128'(exp_disp[i]));
    check({tag, " write count"}, 128'(wr_q.size() - w0), 128'(2));
    if (wr_q.size() >= w0 + 2) begin
      check({tag, " status write"}, 128'(wr_q[w0]), 128'({8'd1, status}));
      check({tag, " ready clear"}, 128'(wr_q[w0+1]), 128'(40'd0));
    end
    check({tag, " err_count"}, 128'(err_count), 128'(exp_err));
    check({tag, " busy after"}, 128'(busy), 128'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " sram_write"}, 128'(bus.sram_write), 128'(0));
    check({tag, " sram_address"}, 128'(bus.sram_address), 128'(0));
    check({tag, " sram_writedata"}, 128'(bus.sram_writedata), 128'(0));
    check({tag, " col_select"}, 128'(bus.col_select), 128'(0));
    check({tag, " row_select"}, 128'(bus.row_select), 128'(0));
    check({tag, " pixel_color"}, 128'(bus.pixel_color), 128'(0));
    check({tag, " busy"}, 128'(busy), 128'(0));
    check({tag, " batch_done"}, 128'(batch_done), 128'(0));
    check({tag, " err_count"}, 128'(err_count), 128'(0));
  endtask

  initial begin
    int w0, b0, r0, cnt;
    bit mode;

    // Reset with an empty mailbox
    for (int i = 0; i < 256; i++) stage[i] = '0;
    load_req = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    load_req = 1'b0;
    check_reset_values("reset");
    reset = 1'b0;

    // Nothing ready: only polls of address 0, no writes, never busy
    w0 = wr_q.size();
    b0 = busy_cycles;
    r0 = rd_nonzero;
    repeat (50) @(negedge clock);
    check("idle writes", 128'(wr_q.size() - w0), 128'(0));
    check("idle busy", 128'(busy_cycles - b0), 128'(0));
    check("idle nonzero reads", 128'(rd_nonzero - r0), 128'(0));

    // Three in-range points, point colours
    pts_q.delete();
    pts_q.push_back(pt(5, 7, 8'h3C));
    pts_q.push_back(pt(63, 479, 8'h01));
    pts_q.push_back(pt(0, 0, 8'h80));
    run_batch("three_pts", 3, 1'b1, 300);

    // Constant colour mode
    pts_q.delete();
    pts_q.push_back(pt(10, 20, 8'h11));
    run_batch("const_color", 1, 1'b0, 200);

    // Out-of-range x and y
    pts_q.delete();
    pts_q.push_back(pt(64, 5, 8'h01));
    pts_q.push_back(pt(3, 480, 8'h02));
    run_batch("range", 2, 1'b1, 200);

    // No acknowledge on column 3 while other columns see noise
    ack_en   = 1'b0;
    noise_en = 1'b1;
    pts_q.delete();
    pts_q.push_back(pt(3, 9, 8'h55));
    run_batch("timeout", 1, 1'b1, 2000);
    check("timeout request length", 128'(last_run), 128'(TMO));
    ack_en = 1'b1;

    // Randomised batches, including empty ones
    for (int k = 0; k < 6; k++) begin
      cnt  = int'($urandom_range(0, 6));
      mode = 1'($urandom_range(0, 1));
      pts_q.delete();
      for (int i = 0; i < cnt; i++)
        pts_q.push_back(pt(int'($urandom_range(0, 70)), int'($urandom_range(0, 500)),
                           int'($urandom_range(0, 255))));
      ack_delay = $urandom_range(0, 4);
      run_batch($sformatf("rnd%0d", k), cnt, mode, 400);
    end

    // Oversized header count clamps to the mailbox
    noise_en  = 1'b0;
    ack_delay = 0;
    pts_q.delete();
    for (int i = 0; i < 254; i++)
      pts_q.push_back(pt(int'($urandom_range(0, NC - 1)), int'($urandom_range(0, NR - 1)),
                         int'($urandom_range(0, 255))));
    run_batch("clamp", 300, 1'b1, 6000);

    // Reset while a request waits for its acknowledge
    ack_en = 1'b0;
    pts_q.delete();
    pts_q.push_back(pt(7, 1, 8'h22));
    pts_q.push_back(pt(8, 2, 8'h33));
    load_batch(2, 1'b1);
    for (int c = 0; c < 200 && bus.col_select == '0; c++) @(negedge clock);
    check("mid request col_select", 128'(bus.col_select), 128'(64'h80));
    repeat (5) @(negedge clock);
    w0 = wr_q.size();
    for (int i = 0; i < 256; i++) stage[i] = '0;
    load_req = 1'b1;
    reset    = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
    check_reset_values("mid reset");
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    exp_err = 0;
    ack_en  = 1'b1;
    repeat (30) @(negedge clock);
    check("post reset writes", 128'(wr_q.size() - w0), 128'(0));
    check("post reset busy", 128'(busy), 128'(0));

    pts_q.delete();
    pts_q.push_back(pt(1, 2, 8'h03));
    run_batch("post_reset", 1, 1'b1, 300);

    check("one-hot violations", 128'(bad_onehot), 128'(0));
    check("request stability", 128'(unstable), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
